d_stage_sb: RTL

Parametrised decode pipeline stage with a register scoreboard. It sits between the combinational instruction decoder/regfile and the execute stage. It registers one decoded instruction per cycle under a valid/ready handshake and tracks in-flight register writes. It stalls on RAW/WAW hazards, forwards same-cycle writeback data, and kills its held instruction on a branch flush.

---
 rtl/d_stage_sb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/d_stage_sb.sv
// Decode pipeline register with a register scoreboard: 1-cycle latency from accept to out_valid.
// Backpressure: holds while out_ready=0; stalls in_ready on RAW/WAW hazards or flush.
module d_stage_sb #(
  parameter int XLEN      = 32,
  parameter int REG_W     = 5,
  parameter int CTL_W     = 6,
  parameter int BYPASS_WB = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [REG_W-1:0]      in_rs1,
  input  logic [REG_W-1:0]      in_rs2,
  input  logic [REG_W-1:0]      in_rd,
  input  logic                  in_uses_rs1,
  input  logic                  in_uses_rs2,
  input  logic                  in_wen,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [CTL_W-1:0]      in_alu_ctl,
  input  logic                  in_mem_en,
  input  logic                  in_branch,
  input  logic [XLEN-1:0]       rf_data1,
  input  logic [XLEN-1:0]       rf_data2,
  input  logic                  wb_en,
  input  logic [REG_W-1:0]      wb_sel,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_data1,
  output logic [XLEN-1:0]       out_data2,
  output logic [XLEN-1:0]       out_imm,
  output logic [REG_W-1:0]      out_rs1,
  output logic [REG_W-1:0]      out_rs2,
  output logic [REG_W-1:0]      out_rd,
  output logic                  out_wen,
  output logic                  out_mem_en,
  output logic                  out_branch,
  output logic [CTL_W-1:0]      out_alu_ctl,
  output logic                  hazard_stall,
  output logic [2**REG_W-1:0]   sb_pending
);

  localparam int NREGS = 2**REG_W;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             mem_en;
    logic             branch;
    logic [CTL_W-1:0] alu_ctl;
  } instr_t;

  instr_t           held;
  instr_t           incoming;
  logic             held_vld;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             hit1;
  logic             hit2;
  logic             hitd;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             accept;

  function automatic logic wbhit(input logic en, input logic [REG_W-1:0] sel,
                                 input logic [REG_W-1:0] r);
    return (BYPASS_WB != 0) && en && (sel == r) && (r != '0);
  endfunction

  assign hit1 = wbhit(wb_en, wb_sel, in_rs1);
  assign hit2 = wbhit(wb_en, wb_sel, in_rs2);
  assign hitd = wbhit(wb_en, wb_sel, in_rd);

  assign raw1 = in_uses_rs1 && (in_rs1 != '0) && pending[in_rs1] && !hit1;
  assign raw2 = in_uses_rs2 && (in_rs2 != '0) && pending[in_rs2] && !hit2;
  assign waw  = in_wen && (in_rd != '0) && pending[in_rd] && !hitd;

  assign hazard_stall = in_valid && (raw1 || raw2 || waw);
  assign in_ready     = !hazard_stall && !flush && (!held_vld || out_ready);
  assign accept       = in_valid && in_ready;

  always_comb begin
    incoming         = '0;
    incoming.pc      = in_pc;
    incoming.data1   = hit1 ? wb_data : rf_data1;
    incoming.data2   = hit2 ? wb_data : rf_data2;
    incoming.imm     = in_imm;
    incoming.rs1     = in_rs1;
    incoming.rs2     = in_rs2;
    incoming.rd      = in_rd;
    incoming.wen     = in_wen;
    incoming.mem_en  = in_mem_en;
    incoming.branch  = in_branch;
    incoming.alu_ctl = in_alu_ctl;
  end

  // Clears first so a same-cycle set of the same index wins. WAW stalling keeps
  // at most one writer per register, so killing the held writer is an exact clear.
  always_comb begin
    pending_nxt = pending;
    if (wb_en && (wb_sel != '0))
      pending_nxt[wb_sel] = 1'b0;
    if (flush && held_vld && held.wen && (held.rd != '0))
      pending_nxt[held.rd] = 1'b0;
    if (accept && in_wen && (in_rd != '0))
      pending_nxt[in_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_vld <= 1'b0;
      held     <= '0;
    end else if (flush) begin
      held_vld <= 1'b0;
    end else if (accept) begin
      held_vld <= 1'b1;
      held     <= incoming;
    end else if (out_ready) begin
      held_vld <= 1'b0;
    end
  end

  assign out_valid   = held_vld;
  assign out_pc      = held.pc;
  assign out_data1   = held.data1;
  assign out_data2   = held.data2;
  assign out_imm     = held.imm;
  assign out_rs1     = held.rs1;
  assign out_rs2     = held.rs2;
  assign out_rd      = held.rd;
  assign out_wen     = held.wen;
  assign out_mem_en  = held.mem_en;
  assign out_branch  = held.branch;
  assign out_alu_ctl = held.alu_ctl;
  assign sb_pending  = pending;

endmodule
